line_filler: RTL

LINE_FILLER -- requirements
Module: line_filler

---
 rtl/line_filler_pkg.sv | 17 +
 rtl/line_filler_if.sv | 11 +
 rtl/line_filler_span_mask.sv | 24 ++
 rtl/line_filler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/line_filler_pkg.sv
// Shared types and constants for the line filler: FSM states, word geometry
// and bus widths of the off-screen line buffer.
package line_pkg;
  localparam int PIX_PER_WORD   = 16;
  localparam int PIX_SHIFT      = 4;
  localparam int LINE_WORDS_DEF = 80;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = PIX_PER_WORD * BYTE_W;
  localparam int ADDR_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BG,
    ST_SPAN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/line_filler_if.sv
// Write port into the off-screen line buffer; byte i of a word is pixel 16*addr+i.
interface line_filler_if;
  import line_pkg::*;

  logic [ADDR_W-1:0]       addr_off_draw;
  logic [PIX_PER_WORD-1:0] we_off_draw;
  logic [WORD_W-1:0]       colour_off_draw;

  modport master (output addr_off_draw, output we_off_draw, output colour_off_draw);
  modport slave  (input  addr_off_draw, input  we_off_draw, input  colour_off_draw);
endinterface

// File: rtl/line_filler_span_mask.sv
// Per-pixel byte enables for one buffer word: pixel 16*w+i is enabled when it
// lies inside the inclusive span [x0, x1c].
module span_mask
  import line_pkg::*;
#(
  parameter int CORDW = 11
) (
  input  logic [ADDR_W-1:0]       w,
  input  logic [CORDW-1:0]        x0,
  input  logic [CORDW-1:0]        x1c,
  output logic [PIX_PER_WORD-1:0] mask
);
  logic [CORDW:0] base;

  assign base = (CORDW+1)'({w, {PIX_SHIFT{1'b0}}});

  always_comb begin
    mask = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      mask[i] = ({1'b0, x0} <= base + (CORDW+1)'(i)) &&
                (base + (CORDW+1)'(i) <= {1'b0, x1c});
    end
  end
endmodule

// File: rtl/line_filler.sv
// Renders one display line into the off buffer: a gradient background pass
// over every word, then an optional solid-colour span written on top of it.
module line_filler
  import line_pkg::*;
#(
  parameter int CORDW      = 11,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic             clk_draw,
  input  logic             rst_draw_n,
  input  logic             line_start,
  input  logic [CORDW-1:0] line_y,
  input  logic [7:0]       bg_base,
  input  logic             span_en,
  input  logic [CORDW-1:0] span_x0,
  input  logic [CORDW-1:0] span_x1,
  input  logic [7:0]       span_colour,
  line_filler_if.master    wr,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam logic [CORDW:0]    LAST_PIX  = (CORDW+1)'(PIX_PER_WORD * LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(LINE_WORDS - 1);

  state_t                  state, state_n;
  logic [ADDR_W-1:0]       w, w_n;
  logic [7:0]              y_q, base_q, col_q;
  logic                    en_q;
  logic [CORDW-1:0]        x0_q, x1_q, x1c;
  logic                    span_ok;
  logic [ADDR_W-1:0]       span_first, span_last;
  logic [PIX_PER_WORD-1:0] mask;
  logic                    wr_en;
  logic [PIX_PER_WORD-1:0] wr_we;
  logic [WORD_W-1:0]       wr_col;
  logic [ADDR_W-1:0]       addr_q;
  logic [PIX_PER_WORD-1:0] we_q;
  logic [WORD_W-1:0]       colour_q;
  logic                    unused_y_hi;

  // Only the low byte of the line number feeds the background gradient.
  assign unused_y_hi = ^line_y[CORDW-1:8];

  always_comb begin
    x1c = x1_q;
    if ({1'b0, x1_q} > LAST_PIX) x1c = CORDW'(LAST_PIX);
  end

  assign span_ok    = en_q && (x0_q <= x1_q) && ({1'b0, x0_q} <= LAST_PIX);
  assign span_first = ADDR_W'(x0_q >> PIX_SHIFT);
  assign span_last  = ADDR_W'(x1c >> PIX_SHIFT);

  span_mask #(.CORDW(CORDW)) u_span_mask (
    .w    (w),
    .x0   (x0_q),
    .x1c  (x1c),
    .mask (mask)
  );

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state <= ST_IDLE;
      w     <= '0;
    end else begin
      state <= state_n;
      w     <= w_n;
    end
  end

  always_comb begin
    state_n = state;
    w_n     = w;
    wr_en   = 1'b0;
    wr_we   = '0;
    wr_col  = '0;
    case (state)
      ST_IDLE: begin
        w_n = '0;
        if (line_start) state_n = ST_BG;
      end
      ST_BG: begin
        wr_en = 1'b1;
        wr_we = '1;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
          wr_col[i*BYTE_W +: BYTE_W] = y_q + base_q + {w[3:0], 4'h0} + 8'(i);
        end
        if (w == LAST_WORD) begin
          if (span_ok) begin
            state_n = ST_SPAN;
            w_n     = span_first;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          w_n = w + 1'b1;
        end
      end
      ST_SPAN: begin
        wr_en  = 1'b1;
        wr_we  = mask;
        wr_col = {PIX_PER_WORD{col_q}};
        if (w == span_last) state_n = ST_DONE;
        else                w_n     = w + 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      y_q    <= '0;
      base_q <= '0;
      en_q   <= 1'b0;
      x0_q   <= '0;
      x1_q   <= '0;
      col_q  <= '0;
    end else if (state == ST_IDLE && line_start) begin
      y_q    <= line_y[7:0];
      base_q <= bg_base;
      en_q   <= span_en;
      x0_q   <= span_x0;
      x1_q   <= span_x1;
      col_q  <= span_colour;
    end
  end

  // Outputs lag the FSM by one cycle so everything leaving the block is a flop.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      addr_q   <= '0;
      we_q     <= '0;
      colour_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      we_q <= wr_we;
      if (wr_en) begin
        addr_q   <= w;
        colour_q <= wr_col;
      end
      busy <= (state == ST_BG) || (state == ST_SPAN);
      done <= (state == ST_DONE);
      if (line_start && state != ST_IDLE) overrun <= 1'b1;
    end
  end

  assign wr.addr_off_draw   = addr_q;
  assign wr.we_off_draw     = we_q;
  assign wr.colour_off_draw = colour_q;
endmodule
